// File: rtl/nav_pkg.sv
// Shared types and helpers for the vacuum-robot navigation controller:
// FSM states, default timing, motor-command bundle and its Moore decode.
package nav_pkg;

  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    AVANCA    = 3'd1,
    RECUA     = 3'd2,
    GIRA_ESQ  = 3'd3,
    GIRA_DIR  = 3'd4,
    PRESO     = 3'd5
  } nav_state_e;

  localparam int DEB_CYCLES_DEF  = 16;
  localparam int BACK_CYCLES_DEF = 32;
  localparam int TURN_CYCLES_DEF = 24;

  typedef struct packed {
    logic frente;
    logic atras;
    logic gira_esq;
    logic gira_dir;
  } motor_cmd_t;

  function automatic motor_cmd_t motor_decode(input nav_state_e st);
    motor_cmd_t cmd;
    cmd = 4'b0000;
    case (st)
      AVANCA:   cmd.frente   = 1'b1;
      RECUA:    cmd.atras    = 1'b1;
      GIRA_ESQ: cmd.gira_esq = 1'b1;
      GIRA_DIR: cmd.gira_dir = 1'b1;
      default:  cmd = 4'b0000;
    endcase
    return cmd;
  endfunction

  // Escape decision: left side preferred, trapped when both sides blocked.
  function automatic nav_state_e decide(input logic le_s, input logic ld_s);
    nav_state_e st;
    if (!le_s) begin
      st = GIRA_ESQ;
    end else if (!ld_s) begin
      st = GIRA_DIR;
    end else begin
      st = PRESO;
    end
    return st;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Power button conditioning: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each accepted rising level.
module debounce_botao
  import nav_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic pulso
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          estavel_r;
  logic          pulso_r;
  logic [CW-1:0] cnt_r;

  // Counts consecutive samples differing from the accepted level; a full run flips it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      estavel_r <= 1'b0;
      pulso_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else begin
      sync1_r <= botao;
      sync2_r <= sync1_r;
      pulso_r <= 1'b0;
      if (sync2_r == estavel_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        estavel_r <= sync2_r;
        pulso_r   <= sync2_r;
        cnt_r     <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign pulso = pulso_r;

endmodule

// File: rtl/controle_navegacao.sv
// Motion controller: registered power state, battery cutoff and an
// obstacle-avoidance FSM sequencing reverse/turn manoeuvres.
module controle_navegacao
  import nav_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int BACK_CYCLES = BACK_CYCLES_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  input  logic bateria,
  input  logic F,
  input  logic T,
  input  logic LE,
  input  logic LD,
  output logic Frente,
  output logic Atras,
  output logic GiraEsq,
  output logic GiraDir,
  output logic ligado,
  output logic ERRO
);

  localparam int MAXC = (BACK_CYCLES > TURN_CYCLES) ? BACK_CYCLES : TURN_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BACK_END = CW'(BACK_CYCLES - 1);
  localparam logic [CW-1:0] TURN_END = CW'(TURN_CYCLES - 1);

  logic [4:0]    sens1_r;
  logic [4:0]    sens2_r;
  logic          bateria_s, f_s, t_s, le_s, ld_s;
  logic          pulso_s;
  nav_state_e    state_r;
  nav_state_e    motion_s;
  nav_state_e    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  motor_cmd_t    cmd_r;
  logic          ligado_r;
  logic          erro_r;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .botao (botao),
    .pulso (pulso_s)
  );

  // Two-flop synchronizers for battery and the four obstacle sensors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sens1_r <= 5'b00000;
      sens2_r <= 5'b00000;
    end else begin
      sens1_r <= {bateria, F, T, LE, LD};
      sens2_r <= sens1_r;
    end
  end

  assign {bateria_s, f_s, t_s, le_s, ld_s} = sens2_r;

  // Next state: obstacle sequencing, then battery and button overrides.
  always_comb begin
    motion_s = state_r;
    case (state_r)
      AVANCA: begin
        if (!f_s) begin
          motion_s = AVANCA;
        end else if (!t_s) begin
          motion_s = RECUA;
        end else begin
          motion_s = decide(le_s, ld_s);
        end
      end
      RECUA: begin
        if (t_s || (cnt_r == BACK_END)) begin
          motion_s = decide(le_s, ld_s);
        end else begin
          motion_s = RECUA;
        end
      end
      GIRA_ESQ: begin
        if (le_s) begin
          motion_s = PRESO;
        end else if (cnt_r == TURN_END) begin
          motion_s = AVANCA;
        end else begin
          motion_s = GIRA_ESQ;
        end
      end
      GIRA_DIR: begin
        if (ld_s) begin
          motion_s = PRESO;
        end else if (cnt_r == TURN_END) begin
          motion_s = AVANCA;
        end else begin
          motion_s = GIRA_DIR;
        end
      end
      PRESO: begin
        if (!f_s && (!le_s || !ld_s)) begin
          motion_s = AVANCA;
        end else begin
          motion_s = PRESO;
        end
      end
      default: motion_s = DESLIGADO;
    endcase

    state_s = motion_s;
    if (!bateria_s) begin
      state_s = DESLIGADO;
    end else if (pulso_s) begin
      state_s = (state_r == DESLIGADO) ? AVANCA : DESLIGADO;
    end else begin
      state_s = motion_s;
    end
  end

  // Manoeuvre timer: restarts on every state entry, runs only while reversing/turning.
  always_comb begin
    cnt_s = cnt_r;
    if (state_s != state_r) begin
      cnt_s = {CW{1'b0}};
    end else if ((state_r == RECUA) || (state_r == GIRA_ESQ) || (state_r == GIRA_DIR)) begin
      cnt_s = cnt_r + 1'b1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State, timer and outputs registered together so outputs always decode state_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= DESLIGADO;
      cnt_r    <= {CW{1'b0}};
      cmd_r    <= 4'b0000;
      ligado_r <= 1'b0;
      erro_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      cmd_r    <= motor_decode(state_s);
      ligado_r <= (state_s != DESLIGADO);
      erro_r   <= (state_s == PRESO);
    end
  end

  assign Frente  = cmd_r.frente;
  assign Atras   = cmd_r.atras;
  assign GiraEsq = cmd_r.gira_esq;
  assign GiraDir = cmd_r.gira_dir;
  assign ligado  = ligado_r;
  assign ERRO    = erro_r;

endmodule
